// File: rtl/br_ctrl_types.sv
// Types for the branch-mispredict recovery sequencer.
package br_ctrl_types;
    typedef enum logic [1:0] {
        BR_REC_IDLE  = 2'd0,
        BR_REC_PEND  = 2'd1,
        BR_REC_FLUSH = 2'd2,
        BR_REC_DRAIN = 2'd3
    } br_rec_state_t;
endpackage

// File: rtl/cpu_params.sv
// Core-wide sizing constants shared by the ROB, LSQ and branch recovery logic.
package cpu_params;
    localparam int ROB_IDX_W = 5;
    localparam int ROB_DEPTH = 1 << ROB_IDX_W;
endpackage

// File: rtl/rob_age_cmp.sv
// ROB age comparator: a is at least as old as b, measured as distance from the
// head modulo the ROB depth. Purely combinational; also used by the LSQ.
module rob_age_cmp #(
    parameter int W = 5
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] head,
    output logic         a_le_b
);
    logic [W-1:0] age_a;
    logic [W-1:0] age_b;

    // Wrap-around distances from the head; the W-bit result is the modulo.
    always_comb begin
        age_a  = a - head;
        age_b  = b - head;
        a_le_b = (age_a <= age_b);
    end
endmodule

// File: rtl/br_recovery_ctrl.sv
// Branch-mispredict recovery sequencer. Holds the oldest outstanding
// mispredicted branch, flushes the backend and redirects the frontend when it
// commits, then stalls branch-RS issue for a fixed drain window.
//
//   state | meaning
//   IDLE  | no mispredict outstanding
//   PEND  | mispredict latched, waiting for it to reach the ROB head and commit
//   FLUSH | single cycle: backend_flush + redirect strobe
//   DRAIN | issue stalled while the frontend refills
module br_recovery_ctrl
    import br_ctrl_types::*;
#(
    parameter int ROB_IDX_W    = cpu_params::ROB_IDX_W,
    parameter int DRAIN_CYCLES = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 br_valid,
    input  logic [ROB_IDX_W-1:0] br_rob_id,
    input  logic                 br_miss_predict,
    input  logic [31:0]          br_target,
    input  logic [ROB_IDX_W-1:0] rob_head,
    input  logic                 rob_head_commit,
    output logic                 backend_flush,
    output logic                 redirect_valid,
    output logic [31:0]          redirect_pc,
    output logic                 issue_stall,
    output logic [31:0]          mispredict_cnt
);
    localparam int DCW = $clog2(DRAIN_CYCLES + 1);

    br_rec_state_t        state;
    logic [ROB_IDX_W-1:0] pend_id;
    logic [31:0]          pend_target;
    logic [DCW-1:0]       drain_cnt;

    logic accept;
    logic new_is_older;
    logic commit_hit;

    rob_age_cmp #(.W(ROB_IDX_W)) u_age_cmp (
        .a      (br_rob_id),
        .b      (pend_id),
        .head   (rob_head),
        .a_le_b (new_is_older)
    );

    // Event qualification; traffic during FLUSH/DRAIN predates the flush.
    always_comb begin
        accept     = br_valid && br_miss_predict &&
                     (state == BR_REC_IDLE || state == BR_REC_PEND);
        commit_hit = (state == BR_REC_PEND) && rob_head_commit &&
                     (rob_head == pend_id);
    end

    // redirect_pc mirrors the pending-target register directly.
    assign redirect_pc = pend_target;

    // Recovery FSM with registered outputs and the saturating event counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= BR_REC_IDLE;
            pend_id        <= '0;
            pend_target    <= '0;
            drain_cnt      <= '0;
            mispredict_cnt <= '0;
            backend_flush  <= 1'b0;
            redirect_valid <= 1'b0;
            issue_stall    <= 1'b0;
        end else begin
            backend_flush  <= 1'b0;
            redirect_valid <= 1'b0;

            // Dropped (younger) and commit-cycle events are still counted.
            if (accept && (mispredict_cnt != 32'hFFFF_FFFF)) begin
                mispredict_cnt <= mispredict_cnt + 32'd1;
            end

            case (state)
                BR_REC_IDLE: begin
                    if (accept) begin
                        pend_id     <= br_rob_id;
                        pend_target <= br_target;
                        state       <= BR_REC_PEND;
                    end
                end
                BR_REC_PEND: begin
                    // The commit wins: any same-cycle result is younger.
                    if (commit_hit) begin
                        state          <= BR_REC_FLUSH;
                        backend_flush  <= 1'b1;
                        redirect_valid <= 1'b1;
                        issue_stall    <= 1'b1;
                    end else if (accept && new_is_older) begin
                        pend_id     <= br_rob_id;
                        pend_target <= br_target;
                    end
                end
                BR_REC_FLUSH: begin
                    drain_cnt <= DCW'(DRAIN_CYCLES);
                    state     <= BR_REC_DRAIN;
                end
                BR_REC_DRAIN: begin
                    drain_cnt <= drain_cnt - DCW'(1);
                    if (drain_cnt == DCW'(1)) begin
                        state       <= BR_REC_IDLE;
                        issue_stall <= 1'b0;
                    end
                end
                default: begin
                    state       <= BR_REC_IDLE;
                    issue_stall <= 1'b0;
                end
            endcase
        end
    end
endmodule
